// File: rtl/iitb_isa_pkg.sv
// Shared IITB-RISC ISA constants and the ALU sequencer state type.
package iitb_isa_pkg;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADI  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_LM   = 4'b0110;
  localparam logic [3:0] OP_SM   = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;

  localparam logic [1:0] CZ_NONE = 2'b00;
  localparam logic [1:0] CZ_Z    = 2'b01;
  localparam logic [1:0] CZ_C    = 2'b10;
  localparam logic [1:0] CZ_ALT  = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} seq_state_t;
endpackage

// File: rtl/lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of a mask, plus a non-empty flag.
module lowest_set_bit #(
  parameter int MASKW = 8
) (
  input  logic [MASKW-1:0]         i_mask,
  output logic [$clog2(MASKW)-1:0] o_idx,
  output logic                     o_any
);
  always_comb begin
    o_idx = '0;
    o_any = |i_mask;
    // Scan downward so the lowest set bit is the last to win.
    for (int i = MASKW - 1; i >= 0; i--) begin
      if (i_mask[i]) o_idx = ($clog2(MASKW))'(i);
    end
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// Drives the shared ALU one op at a time, owns C/Z flags, expands LM/SM into address beats.
module alu_op_sequencer
  import iitb_isa_pkg::*;
#(
  parameter int DW    = 16,
  parameter int MASKW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_opcode,
  input  logic [1:0]               in_cz,
  input  logic [DW-1:0]            in_a,
  input  logic [DW-1:0]            in_b,
  input  logic [MASKW-1:0]         in_mask,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  output logic [3:0]               alu_opcode,
  output logic [1:0]               alu_cz,
  output logic                     alu_c_in,
  output logic                     alu_z_in,
  input  logic [DW-1:0]            alu_result,
  input  logic                     alu_c_out,
  input  logic                     alu_z_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_result,
  output logic                     out_wb_en,
  output logic                     out_eq,
  output logic [$clog2(MASKW)-1:0] out_reg_idx,
  output logic                     out_last,
  output logic                     c_flag,
  output logic                     z_flag
);
  localparam int IW = $clog2(MASKW);

  seq_state_t       r_state, w_nstate;
  logic             r_rdy, r_c, r_z;
  logic [3:0]       r_op;
  logic [1:0]       r_cz;
  logic [DW-1:0]    r_alu_a, r_alu_b, r_res;
  logic [MASKW-1:0] r_mask;
  logic             r_out_valid, r_wb, r_eq, r_last;
  logic [IW-1:0]    r_idx;

  logic             w_accept, w_multi, w_in_multi, w_cond, w_any;
  logic [IW-1:0]    w_lsb_idx, w_idx;
  logic [DW-1:0]    w_sum, w_res;
  logic             w_wb, w_eq, w_last, w_c, w_z;

  assign w_accept   = in_valid & r_rdy;
  assign w_multi    = (r_op == OP_LM) || (r_op == OP_SM);
  assign w_in_multi = (in_opcode == OP_LM) || (in_opcode == OP_SM);
  assign w_sum      = r_alu_a + r_alu_b;
  assign w_cond     = (r_cz == CZ_Z) ? r_z : (r_cz == CZ_C) ? r_c : 1'b0;

  lowest_set_bit #(.MASKW(MASKW)) u_lsb (
    .i_mask (r_mask),
    .o_idx  (w_lsb_idx),
    .o_any  (w_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nstate = EXEC;
      EXEC:    w_nstate = HOLD;
      HOLD:    if (out_ready) w_nstate = r_last ? IDLE : EXEC;
      default: w_nstate = IDLE;
    endcase
  end

  // Beat result and flag commit, evaluated while the ALU settles in EXEC.
  always_comb begin
    w_res  = w_sum;
    w_wb   = 1'b0;
    w_eq   = 1'b0;
    w_idx  = '0;
    w_last = 1'b1;
    w_c    = r_c;
    w_z    = r_z;
    case (r_op)
      OP_ADD: begin
        w_res = alu_result; w_wb = 1'b1; w_c = alu_c_out; w_z = alu_z_out;
      end
      OP_ADI: begin
        w_res = alu_result;
        if (r_cz == CZ_NONE || r_cz == CZ_ALT || w_cond) begin
          w_wb = 1'b1; w_c = alu_c_out; w_z = alu_z_out;
        end
      end
      OP_NAND: begin
        w_res = alu_result;
        if (r_cz == CZ_NONE || (r_cz != CZ_ALT && w_cond)) begin
          w_wb = 1'b1; w_z = alu_z_out;
        end
      end
      OP_BEQ: begin
        w_res = alu_result; w_eq = alu_z_out;
      end
      OP_LM, OP_SM: begin
        // Empty mask still yields one beat: address=base, no writeback.
        w_idx  = w_lsb_idx;
        w_last = (r_mask & (r_mask - MASKW'(1))) == '0;
        w_wb   = (r_op == OP_LM) && w_any;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdy <= 1'b0; r_op <= '0; r_cz <= '0; r_alu_a <= '0; r_alu_b <= '0;
      r_mask <= '0; r_c <= 1'b0; r_z <= 1'b0; r_out_valid <= 1'b0;
      r_res <= '0; r_wb <= 1'b0; r_eq <= 1'b0; r_idx <= '0; r_last <= 1'b0;
    end else begin
      r_rdy <= (w_nstate == IDLE);
      if (w_accept) begin
        r_op    <= in_opcode;
        r_cz    <= in_cz;
        r_alu_a <= in_a;
        r_alu_b <= w_in_multi ? '0 : in_b;
        r_mask  <= in_mask;
      end
      if (r_state == EXEC) begin
        r_out_valid <= 1'b1;
        r_res  <= w_res;  r_wb   <= w_wb;   r_eq <= w_eq;
        r_idx  <= w_idx;  r_last <= w_last;
        r_c    <= w_c;    r_z    <= w_z;
      end
      if (r_state == HOLD && out_ready) begin
        r_out_valid <= 1'b0;
        if (!r_last) begin
          r_mask  <= r_mask & (r_mask - MASKW'(1));
          r_alu_b <= r_alu_b + DW'(1);
        end
      end
    end
  end

  assign in_ready    = r_rdy;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_opcode  = w_multi ? OP_LW : r_op;
  assign alu_cz      = r_cz;
  assign alu_c_in    = r_c;
  assign alu_z_in    = r_z;
  assign out_valid   = r_out_valid;
  assign out_result  = r_res;
  assign out_wb_en   = r_wb;
  assign out_eq      = r_eq;
  assign out_reg_idx = r_idx;
  assign out_last    = r_last;
  assign c_flag      = r_c;
  assign z_flag      = r_z;
endmodule
